mmio_port_unit: RTL and testbench

Memory-mapped I/O unit that sits in the ME stage beside the data memory and decodes the same `Address`/`MemWrite`/`MemRead` bus. It drives the processor's 32-bit `PortOut` from a writable output register and presents the 8-bit `PortIn` pins to software. `PortIn` passes through a two-flop synchronizer and a debounce filter, and a sticky status word tracks input changes. The top level uses `IOHit` to select this block's `ReadData` over the data memory's read data and to suppress data-memory writes.

---
 rtl/mmio_port_unit.sv | 152 +++++++++++++++
 tb/tb_mmio_port_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_unit.sv
// Memory-mapped I/O port: a writable 32-bit output register plus a synchronized,
// debounced 8-bit input register with a sticky new_data/overrun status word.
module mmio_port_unit #(
    parameter logic [31:0] OUT_ADDR        = 32'h1001_0024,
    parameter logic [31:0] IN_ADDR         = 32'h1001_0028,
    parameter logic [31:0] STAT_ADDR       = 32'h1001_002C,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        IOHit,
    output logic [31:0] PortOut
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Register slots: 0 = output, 1 = input, 2 = status.
    localparam int NUM_REGS = 3;
    localparam logic [29:0] REG_WORD [NUM_REGS] = '{
        OUT_ADDR[31:2], IN_ADDR[31:2], STAT_ADDR[31:2]
    };

    logic [NUM_REGS-1:0] hit;

    logic [31:0]      out_reg;
    logic [31:0]      out_next;
    logic [7:0]       sync1_reg;
    logic [7:0]       sync2_reg;
    logic [7:0]       cand_reg;
    logic [7:0]       cand_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       in_data_reg;
    logic [7:0]       in_data_next;
    logic             new_data_reg;
    logic             new_data_next;
    logic             overrun_reg;
    logic             overrun_next;

    logic accept;
    logic wr_out;
    logic rd_in;
    logic wr_stat;
    logic clr_new_data;
    logic clr_overrun;
    logic unused_addr_bits;

    // Byte offset within the word is deliberately ignored.
    assign unused_addr_bits = ^Address[1:0];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign hit[gi] = (Address[31:2] == REG_WORD[gi]);
        end
    endgenerate

    assign IOHit   = |hit;
    assign wr_out  = MemWrite && hit[0];
    assign rd_in   = MemRead && hit[1];
    assign wr_stat = MemWrite && hit[2];
    assign PortOut = out_reg;

    always_comb begin
        out_next = out_reg;
        if (wr_out) begin
            out_next = WriteData;
        end
    end

    // Debounce: a new value must be seen on sync2 for DEBOUNCE_CYCLES+1 edges.
    always_comb begin
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        in_data_next = in_data_reg;
        accept       = 1'b0;
        if (sync2_reg == in_data_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == '0 || sync2_reg != cand_reg) begin
            cand_next = sync2_reg;
            cnt_next  = CNT_ONE;
        end else if (cnt_reg == CNT_MAX) begin
            in_data_next = cand_reg;
            cnt_next     = '0;
            accept       = 1'b1;
        end else begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    assign clr_new_data = rd_in || (wr_stat && WriteData[0]);
    assign clr_overrun  = wr_stat && WriteData[1];

    // Sets win over clears; overrun only counts a value that will really be lost.
    always_comb begin
        new_data_next = new_data_reg;
        overrun_next  = overrun_reg;
        if (accept) begin
            new_data_next = 1'b1;
        end else if (clr_new_data) begin
            new_data_next = 1'b0;
        end
        if (accept && new_data_reg && !clr_new_data) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            if (hit[0]) begin
                ReadData = out_reg;
            end else if (hit[1]) begin
                ReadData = {24'h0, in_data_reg};
            end else if (hit[2]) begin
                ReadData = {30'h0, overrun_reg, new_data_reg};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg      <= 32'h0;
            sync1_reg    <= 8'h0;
            sync2_reg    <= 8'h0;
            cand_reg     <= 8'h0;
            cnt_reg      <= '0;
            in_data_reg  <= 8'h0;
            new_data_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            out_reg      <= out_next;
            sync1_reg    <= PortIn;
            sync2_reg    <= sync1_reg;
            cand_reg     <= cand_next;
            cnt_reg      <= cnt_next;
            in_data_reg  <= in_data_next;
            new_data_reg <= new_data_next;
            overrun_reg  <= overrun_next;
        end
    end

endmodule

// File: tb/tb_mmio_port_unit.sv
// Scenario bench for mmio_port_unit: loads push expected data to a scoreboard
// queue and each scenario drains and compares it.
module tb_mmio_port_unit;

    localparam logic [31:0] OUT_ADDR  = 32'h1001_0024;
    localparam logic [31:0] IN_ADDR   = 32'h1001_0028;
    localparam logic [31:0] STAT_ADDR = 32'h1001_002C;
    localparam logic [31:0] RAM_ADDR  = 32'h1001_0000;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        IOHit;
    logic [31:0] PortOut;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    string       name_q[$];

    mmio_port_unit #(
        .OUT_ADDR(OUT_ADDR),
        .IN_ADDR(IN_ADDR),
        .STAT_ADDR(STAT_ADDR),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .PortIn(PortIn),
        .ReadData(ReadData),
        .IOHit(IOHit),
        .PortOut(PortOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One load spanning exactly one rising edge; expected value goes to the scoreboard.
    task automatic load(input string name, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        name_q.push_back(name);
        Address  = a;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        #1;
        obs_q.push_back(ReadData);
        $display("load  %-14s addr=%h data=%h", name, a, ReadData);
        @(negedge clk);
        idle();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        $display("store addr=%h data=%h", a, d);
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] e, o;
        string n;
        PortIn    = 8'hFF;
        reset     = 1'b1;
        Address   = OUT_ADDR;
        WriteData = 32'hFFFF_FFFF;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        cyc(2);
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (PortOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_portout: PortOut=%h expected %h", PortOut, 32'h0);
        end
        @(negedge clk);
        // Released before edge k; PortIn=FF is accepted on edge k+6.
        load("rst_stat", STAT_ADDR, 32'h0);
        load("rst_out", OUT_ADDR, 32'h0);
        load("rst_in", IN_ADDR, 32'h0);
        cyc(2);
        load("rst_in_early", IN_ADDR, 32'h0);
        load("rst_in_ff", IN_ADDR, 32'hFF);
        load("rst_stat_clr", STAT_ADDR, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: ReadData=%h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_output();
        logic [31:0] e, o;
        string n;
        store(OUT_ADDR, 32'hDEAD_BEEF);
        checks++;
        if (PortOut !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL out_store: PortOut=%h expected %h", PortOut, 32'hDEAD_BEEF);
        end
        Address = OUT_ADDR;
        #1;
        checks++;
        if (IOHit !== 1'b1 || ReadData !== 32'h0) begin
            errors++;
            $display("FAIL out_noread: IOHit=%b ReadData=%h expected 1 00000000", IOHit, ReadData);
        end
        @(negedge clk);
        idle();
        load("out_load", OUT_ADDR, 32'hDEAD_BEEF);
        load("out_byteoff", OUT_ADDR | 32'h3, 32'hDEAD_BEEF);
        load("ram_load", RAM_ADDR, 32'h0);
        Address = RAM_ADDR;
        MemRead = 1'b1;
        #1;
        checks++;
        if (IOHit !== 1'b0) begin
            errors++;
            $display("FAIL ram_iohit: IOHit=%b expected 0", IOHit);
        end
        @(negedge clk);
        idle();
        store(RAM_ADDR, 32'h1234_5678);
        checks++;
        if (PortOut !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_store: PortOut=%h expected %h", PortOut, 32'hDEAD_BEEF);
        end
        // Read and write on the same edge: read sees the pre-edge value.
        exp_q.push_back(32'hDEAD_BEEF);
        name_q.push_back("rw_same_edge");
        Address = OUT_ADDR; WriteData = 32'hCAFE_F00D; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        obs_q.push_back(ReadData);
        $display("rdwr  addr=%h wdata=%h rdata=%h", Address, WriteData, ReadData);
        @(negedge clk);
        idle();
        checks++;
        if (PortOut !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rw_portout: PortOut=%h expected %h", PortOut, 32'hCAFE_F00D);
        end
        store(IN_ADDR, 32'h0000_00AA);
        load("in_ro", IN_ADDR, 32'hFF);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: ReadData=%h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_input_change();
        logic [31:0] e, o;
        string n;
        PortIn = 8'h00;
        cyc(10);
        load("settle_stat", STAT_ADDR, 32'h1);
        load("settle_in", IN_ADDR, 32'h0);
        load("settle_clr", STAT_ADDR, 32'h0);
        PortIn = 8'h5A;
        cyc(5);
        load("chg_in_k5", IN_ADDR, 32'h0);
        load("chg_stat_k6", STAT_ADDR, 32'h0);
        load("chg_stat_new", STAT_ADDR, 32'h1);
        load("chg_in_5a", IN_ADDR, 32'h5A);
        load("chg_stat_clr", STAT_ADDR, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: ReadData=%h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] e, o;
        string n;
        PortIn = 8'h00;
        cyc(10);
        load("gl_pre_stat", STAT_ADDR, 32'h1);
        load("gl_pre_in", IN_ADDR, 32'h0);
        PortIn = 8'h5A;
        cyc(3);
        PortIn = 8'h00;
        cyc(10);
        load("gl_in", IN_ADDR, 32'h0);
        load("gl_stat", STAT_ADDR, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: ReadData=%h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] e, o;
        string n;
        PortIn = 8'h11;
        cyc(10);
        PortIn = 8'h22;
        cyc(10);
        load("ovr_stat", STAT_ADDR, 32'h3);
        store(STAT_ADDR, 32'h2);
        load("ovr_clr_ov", STAT_ADDR, 32'h1);
        store(STAT_ADDR, 32'h1);
        load("ovr_clr_nd", STAT_ADDR, 32'h0);
        load("ovr_in", IN_ADDR, 32'h22);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: ReadData=%h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] e, o;
        string n;
        PortIn = 8'h33;
        cyc(10);
        PortIn = 8'h44;
        cyc(6);
        // This load spans the accept edge of 8'h44 while new_data is already set.
        load("col_in_old", IN_ADDR, 32'h33);
        load("col_stat", STAT_ADDR, 32'h1);
        load("col_in_new", IN_ADDR, 32'h44);
        load("col_stat_clr", STAT_ADDR, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: ReadData=%h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0000_0001;
        vals[1] = 32'h8000_0000;
        vals[2] = 32'h5555_AAAA;
        vals[3] = 32'hFFFF_FFFF;
        Address  = OUT_ADDR;
        MemWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WriteData = vals[i];
            @(negedge clk);
            $display("b2b   store %0d data=%h PortOut=%h", i, vals[i], PortOut);
            checks++;
            if (PortOut !== vals[i]) begin
                errors++;
                $display("FAIL b2b_%0d: PortOut=%h expected %h", i, PortOut, vals[i]);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset  = 1'b1;
        PortIn = 8'hFF;
        @(negedge clk);
        test_reset();
        test_output();
        test_input_change();
        test_glitch();
        test_overrun();
        test_collision();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
